// File: rtl/postmortem_reader_if.sv
// ============================================================================
//  Module      : postmortem_reader_if
//  Description : AXI4-Stream dump channel used by the post-mortem reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface postmortem_reader_if;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

`default_nettype wire

// File: rtl/postmortem_reader.sv
// ============================================================================
//  Module      : postmortem_reader
//  Description : Dumps a frozen multi-channel ring buffer, oldest sample first,
//                over AXI4-Stream (one 32-bit word per channel per sample).
//                Optional macro POSTMORTEM_READER_HEADER_EN prepends a single
//                header beat {last_ptr, CH_NUM, 8'hA5} to every dump.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module postmortem_reader #(
    parameter int DEPTH  = 50000,
    parameter int CH_NUM = 10
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_frozen,
    input  wire logic [15:0]           i_w_ram_addr,
    input  wire logic                  i_start,
    output logic [15:0]                o_r_ram_addr,
    input  wire logic [32*CH_NUM-1:0]  i_ram_data,
    postmortem_reader_if.master        m_axis,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_abort
);

    localparam int                 c_CH_W      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam logic [15:0]        c_LAST_ADDR = 16'(DEPTH - 1);
    localparam logic [c_CH_W-1:0]  c_LAST_CH   = c_CH_W'(CH_NUM - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_END   = 3'd5;

    logic [2:0]           state_q,    state_d;
    logic [15:0]          ptr_q,      ptr_d;
    logic [15:0]          last_ptr_q, last_ptr_d;
    logic [15:0]          cnt_q,      cnt_d;
    logic [c_CH_W-1:0]    ch_q,       ch_d;
    logic [32*CH_NUM-1:0] shadow_q,   shadow_d;
    logic                 abort_q,    abort_d;
`ifdef POSTMORTEM_READER_HEADER_EN
    logic                 hdr_q,      hdr_d;
`endif

    logic        w_hs;
    logic        w_last_ch;
    logic        w_last_sample;
    logic        w_abort_now;
    logic [15:0] w_ptr_next;
    logic [15:0] w_start_ptr;

    // A beat completes whenever the sink accepts while we are presenting.
    assign w_hs          = (state_q == S_SEND) && m_axis.m_axis_tready;
    assign w_last_ch     = (ch_q == c_LAST_CH);
    // The sample counter backs up the pointer compare so a dump always ends.
    assign w_last_sample = (ptr_q == last_ptr_q) || (cnt_q == c_LAST_ADDR);
    // Abort is sticky once seen, and also reacts to the current cycle's drop.
    assign w_abort_now   = abort_q || !i_frozen;
    assign w_ptr_next    = (ptr_q == c_LAST_ADDR) ? 16'd0 : ptr_q + 16'd1;
    // Oldest sample sits just after the writer pointer, wrapping at DEPTH-1.
    assign w_start_ptr   = (i_w_ram_addr == c_LAST_ADDR) ? 16'd0 : i_w_ram_addr + 16'd1;

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            last_ptr_q <= '0;
            cnt_q      <= '0;
            ch_q       <= '0;
            shadow_q   <= '0;
            abort_q    <= 1'b0;
`ifdef POSTMORTEM_READER_HEADER_EN
            hdr_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            shadow_q   <= shadow_d;
            abort_q    <= abort_d;
`ifdef POSTMORTEM_READER_HEADER_EN
            hdr_q      <= hdr_d;
`endif
        end
    end

    // Next-state and next-datapath logic for the dump sequencer.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_ptr_d = last_ptr_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        shadow_d   = shadow_q;
        abort_d    = abort_q;
`ifdef POSTMORTEM_READER_HEADER_EN
        hdr_d      = hdr_q;
`endif
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (i_start && i_frozen) begin
                    ptr_d      = w_start_ptr;
                    last_ptr_d = i_w_ram_addr;
                    cnt_d      = '0;
                    ch_d       = '0;
`ifdef POSTMORTEM_READER_HEADER_EN
                    hdr_d      = 1'b1;
                    state_d    = S_SEND;
`else
                    state_d    = S_ADDR;
`endif
                end
            end
            S_ADDR: begin
                abort_d = w_abort_now;
                state_d = w_abort_now ? S_END : S_WAIT;
            end
            S_WAIT: begin
                abort_d = w_abort_now;
                state_d = w_abort_now ? S_END : S_LATCH;
            end
            S_LATCH: begin
                abort_d = w_abort_now;
                if (w_abort_now) begin
                    state_d = S_END;
                end else begin
                    shadow_d = i_ram_data;
                    ch_d     = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                abort_d = w_abort_now;
                if (w_hs) begin
`ifdef POSTMORTEM_READER_HEADER_EN
                    if (hdr_q) begin
                        hdr_d   = 1'b0;
                        state_d = w_abort_now ? S_END : S_ADDR;
                    end else
`endif
                    if (!w_last_ch) begin
                        ch_d = ch_q + c_CH_W'(1);
                        if (w_abort_now) begin
                            state_d = S_END;
                        end
                    end else if (w_last_sample) begin
                        // The final beat landed: report completion even if
                        // the freeze dropped on this very cycle.
                        abort_d = 1'b0;
                        state_d = S_END;
                    end else begin
                        ptr_d   = w_ptr_next;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = w_abort_now ? S_END : S_ADDR;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the current state and datapath registers.
    always_comb begin
        o_r_ram_addr         = ptr_q;
        o_busy               = (state_q != S_IDLE);
        o_done               = (state_q == S_END) && !abort_q;
        o_abort              = (state_q == S_END) &&  abort_q;
        m_axis.m_axis_tvalid = (state_q == S_SEND);
        m_axis.m_axis_tdata  = shadow_q[32*int'(ch_q) +: 32];
        m_axis.m_axis_tlast  = (state_q == S_SEND) && w_last_ch && w_last_sample;
`ifdef POSTMORTEM_READER_HEADER_EN
        if (hdr_q) begin
            m_axis.m_axis_tdata = {last_ptr_q, 8'(CH_NUM), 8'hA5};
            m_axis.m_axis_tlast = 1'b0;
        end
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_postmortem_reader.sv
// ============================================================================
//  Module      : tb_postmortem_reader
//  Description : Self-checking bench for postmortem_reader (DEPTH=8, CH_NUM=10)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_postmortem_reader;

    localparam int DEPTH = 8;
    localparam int CH    = 10;
`ifdef POSTMORTEM_READER_HEADER_EN
    localparam int HDR   = 1;
`else
    localparam int HDR   = 0;
`endif
    localparam int TOTAL = DEPTH * CH + HDR;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic              clk;
    logic              rst;
    logic              frozen;
    logic [15:0]       w_addr;
    logic              start;
    logic [15:0]       r_addr;
    logic [32*CH-1:0]  ram_data;
    logic              busy;
    logic              done;
    logic              abort_o;

    postmortem_reader_if axis ();

    beat_t exp_q[$];
    int    checks    = 0;
    int    failures  = 0;
    int    beats     = 0;
    int    done_cnt  = 0;
    int    abort_cnt = 0;
    int    tr_mode   = 0;
    int    cyc       = 0;

    postmortem_reader #(.DEPTH(DEPTH), .CH_NUM(CH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frozen     (frozen),
        .i_w_ram_addr (w_addr),
        .i_start      (start),
        .o_r_ram_addr (r_addr),
        .i_ram_data   (ram_data),
        .m_axis       (axis),
        .o_busy       (busy),
        .o_done       (done),
        .o_abort      (abort_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] a, input int c);
        return {8'hD0, a, 8'(c)};
    endfunction

    // Channel BRAMs with one cycle of read latency.
    always @(posedge clk) begin
        for (int c = 0; c < CH; c++) ram_data[c*32 +: 32] <= word(r_addr, c);
    end

    // Stream monitor: every presented beat must match the scoreboard head.
    always @(negedge clk) begin
        if (rst && axis.m_axis_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_unexpected: got tdata=%h tlast=%b, required no beat", axis.m_axis_tdata, axis.m_axis_tlast);
            end else begin
                if (axis.m_axis_tdata !== exp_q[0].data || axis.m_axis_tlast !== exp_q[0].last) begin
                    failures++;
                    $display("FAIL beat_%0d: got tdata=%h tlast=%b, required tdata=%h tlast=%b",
                             beats + 1, axis.m_axis_tdata, axis.m_axis_tlast, exp_q[0].data, exp_q[0].last);
                end
                if (axis.m_axis_tready) void'(exp_q.pop_front());
            end
            if (axis.m_axis_tready) beats++;
        end
        if (rst && done)    done_cnt++;
        if (rst && abort_o) abort_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        case (tr_mode)
            0: axis.m_axis_tready = 1'b1;
            1: axis.m_axis_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: ;
        endcase
    endtask

    task automatic push_dump(input logic [15:0] w, input int limit);
        int n = 0;
        beat_t b;
        if (HDR != 0 && n < limit) begin
            b.data = {w, 8'(CH), 8'hA5};
            b.last = 1'b0;
            exp_q.push_back(b);
            n++;
        end
        for (int s = 0; s < DEPTH; s++) begin
            for (int c = 0; c < CH; c++) begin
                if (n < limit) begin
                    b.data = word(16'((int'(w) + 1 + s) % DEPTH), c);
                    b.last = (s == DEPTH - 1) && (c == CH - 1);
                    exp_q.push_back(b);
                    n++;
                end
            end
        end
    endtask

    task automatic pulse_start(input logic [15:0] w);
        w_addr = w;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        int n = 0;
        int e0 = done_cnt + abort_cnt;
        while ((done_cnt + abort_cnt) == e0 && n < budget) begin
            tick();
            n++;
        end
        timed_out = (n >= budget);
    endtask

    task automatic test_reset();
        rst = 1'b0; frozen = 1'b0; start = 1'b0; w_addr = 16'd0;
        axis.m_axis_tready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, abort_o, axis.m_axis_tvalid, axis.m_axis_tlast} !== 5'b0 ||
            r_addr !== 16'd0 || axis.m_axis_tdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b abort=%b tvalid=%b tlast=%b addr=%h tdata=%h, required all 0",
                     busy, done, abort_o, axis.m_axis_tvalid, axis.m_axis_tlast, r_addr, axis.m_axis_tdata);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic run_full(input logic [15:0] w, input logic [15:0] first_addr, input string name);
        int  b0 = beats;
        int  d0 = done_cnt;
        int  a0 = abort_cnt;
        bit  to;
        frozen = 1'b1;
        push_dump(w, TOTAL);
        pulse_start(w);
        checks++;
        if (r_addr !== first_addr || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_first_addr: got addr=%0d busy=%b, required addr=%0d busy=1", name, r_addr, busy, first_addr);
        end
        wait_end(3000, to);
        tick();
        checks++;
        if (to || beats - b0 != TOTAL || done_cnt - d0 != 1 || abort_cnt != a0 || busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_complete: got timeout=%b beats=%0d done=%0d abort=%0d busy=%b left=%0d, required beats=%0d done=1 abort=0 busy=0 left=0",
                     name, to, beats - b0, done_cnt - d0, abort_cnt - a0, busy, exp_q.size(), TOTAL);
        end
        checks++;
        if (r_addr !== w) begin
            failures++;
            $display("FAIL %s_last_addr: got %0d, required %0d", name, r_addr, w);
        end
    endtask

    task automatic test_basic();
        tr_mode = 0;
        run_full(16'd3, 16'd4, "basic");
    endtask

    task automatic test_start_ignored();
        int b0 = beats;
        int d0 = done_cnt;
        bit to;
        frozen = 1'b0;
        pulse_start(16'd5);
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || r_addr !== 16'd3 || beats != b0) begin
            failures++;
            $display("FAIL start_unfrozen: got busy=%b addr=%0d beats=%0d, required busy=0 addr=3 beats=0", busy, r_addr, beats - b0);
        end
        // A second start while busy must not disturb the dump in progress.
        frozen = 1'b1;
        tr_mode = 0;
        push_dump(16'd3, TOTAL);
        pulse_start(16'd3);
        repeat (20) tick();
        pulse_start(16'd6);
        wait_end(3000, to);
        tick();
        checks++;
        if (to || beats - b0 != TOTAL || done_cnt - d0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL start_busy: got timeout=%b beats=%0d done=%0d left=%0d, required beats=%0d done=1 left=0",
                     to, beats - b0, done_cnt - d0, exp_q.size(), TOTAL);
        end
    endtask

    task automatic test_wrap();
        tr_mode = 0;
        run_full(16'd7, 16'd0, "wrap");
    endtask

    task automatic test_stall();
        tr_mode = 1;
        run_full(16'd3, 16'd4, "stall");
        tr_mode = 0;
    endtask

    task automatic test_completion_race();
        int b0 = beats;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        int n  = 0;
        bit to;
        tr_mode = 0;
        frozen = 1'b1;
        push_dump(16'd3, TOTAL);
        pulse_start(16'd3);
        while (beats - b0 < TOTAL - 1 && n < 3000) begin
            tick();
            n++;
        end
        frozen = 1'b0;
        wait_end(50, to);
        frozen = 1'b1;
        tick();
        checks++;
        if (to || n >= 3000 || done_cnt - d0 != 1 || abort_cnt != a0 || beats - b0 != TOTAL) begin
            failures++;
            $display("FAIL completion_race: got timeout=%b done=%0d abort=%0d beats=%0d, required done=1 abort=0 beats=%0d",
                     to || n >= 3000, done_cnt - d0, abort_cnt - a0, beats - b0, TOTAL);
        end
    endtask

    task automatic test_abort();
        int b0 = beats;
        int d0 = done_cnt;
        int a0 = abort_cnt;
        int n  = 0;
        bit to;
        tr_mode = 0;
        frozen = 1'b1;
        push_dump(16'd3, 25);
        pulse_start(16'd3);
        while (beats - b0 < 24 && n < 3000) begin
            tick();
            n++;
        end
        tr_mode = 2;
        axis.m_axis_tready = 1'b0;
        tick();
        frozen = 1'b0;
        repeat (3) tick();
        checks++;
        if (axis.m_axis_tvalid !== 1'b1 || busy !== 1'b1 || abort_cnt != a0) begin
            failures++;
            $display("FAIL abort_hold: got tvalid=%b busy=%b abort=%0d, required tvalid=1 busy=1 abort=0",
                     axis.m_axis_tvalid, busy, abort_cnt - a0);
        end
        axis.m_axis_tready = 1'b1;
        wait_end(50, to);
        repeat (5) tick();
        checks++;
        if (to || n >= 3000 || beats - b0 != 25 || abort_cnt - a0 != 1 || done_cnt != d0 || busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_end: got timeout=%b beats=%0d abort=%0d done=%0d busy=%b left=%0d, required beats=25 abort=1 done=0 busy=0 left=0",
                     to || n >= 3000, beats - b0, abort_cnt - a0, done_cnt - d0, busy, exp_q.size());
        end
        frozen  = 1'b1;
        tr_mode = 0;
        tick();
    endtask

    task automatic test_reset_mid_dump();
        int b0 = beats;
        int b1;
        int n  = 0;
        tr_mode = 0;
        frozen = 1'b1;
        push_dump(16'd5, TOTAL);
        pulse_start(16'd5);
        while (beats - b0 < 15 && n < 3000) begin
            tick();
            n++;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (n >= 3000 || axis.m_axis_tvalid !== 1'b0 || busy !== 1'b0 || r_addr !== 16'd0 ||
            axis.m_axis_tdata !== 32'd0 || axis.m_axis_tlast !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_dump: got tvalid=%b busy=%b addr=%0d tdata=%h tlast=%b, required all 0",
                     axis.m_axis_tvalid, busy, r_addr, axis.m_axis_tdata, axis.m_axis_tlast);
        end
        exp_q.delete();
        b1 = beats;
        repeat (3) tick();
        rst = 1'b1;
        repeat (30) tick();
        checks++;
        if (beats != b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_resume: got beats=%0d busy=%b, required beats=0 busy=0", beats - b1, busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_wrap();
        test_stall();
        test_completion_race();
        test_abort();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/postmortem_reader.md
POSTMORTEM_READER -- requirements
Module: postmortem_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 50000, meaning ring-buffer depth in samples.
REQ-002 The block SHALL have parameter CH_NUM, default 10, meaning channels per sample (one 32-bit BRAM per channel, shared address).
REQ-003 The block SHALL have port i_clk  input  1  the single clock for all logic.
REQ-004 The block SHALL have port i_rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port i_frozen  input  1  capture frozen (interlock flag held high).
REQ-006 The block SHALL have port i_w_ram_addr  input  16  writer pointer at freeze.
REQ-007 The block SHALL have port i_start  input  1  single-cycle dump request.
REQ-008 The block SHALL have port o_r_ram_addr  output  16  read address to all channel BRAMs.
REQ-009 The block SHALL have port i_ram_data  input  32*CH_NUM  BRAM read data, channel 0 in bits [31:0].
REQ-010 The block SHALL have ports m_axis_tdata (output, 32), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), together the AXI4-Stream dump output.
REQ-011 The block SHALL have port o_busy  output  1  dump in progress.
REQ-012 The block SHALL have ports o_done (output, 1) and o_abort (output, 1), each a one-cycle completion or abort pulse.

Function
REQ-013 States SHALL be IDLE, ADDR, WAIT, LATCH, SEND and END.
REQ-014 IDLE -> ADDR SHALL occur on i_start=1 while i_frozen=1; i_start SHALL be ignored in any other state or while i_frozen=0.
REQ-015 On start, ptr = (i_w_ram_addr==DEPTH-1) ? 0 : i_w_ram_addr+1 (oldest sample) SHALL be registered, i_w_ram_addr SHALL be latched as last_ptr, and the sample count SHALL be cleared.
REQ-016 ADDR SHALL drive o_r_ram_addr=ptr; WAIT SHALL be a fixed 1-cycle BRAM latency; LATCH SHALL capture all of i_ram_data into a 32*CH_NUM shadow register.
REQ-017 SEND SHALL output channel 0..CH_NUM-1 in order, one word per beat, with tvalid held high until the tready handshake.
REQ-018 While tvalid=1 and tready=0, tdata and tlast SHALL remain stable.
REQ-019 m_axis_tlast SHALL be 1 only on channel CH_NUM-1 of the sample at last_ptr; exactly DEPTH*CH_NUM beats SHALL be emitted per dump.
REQ-020 After the last channel handshake, ptr SHALL advance with wrap DEPTH-1 -> 0 and return to ADDR, or go to END if ptr==last_ptr.
REQ-021 END SHALL pulse o_done for 1 cycle and then enter IDLE.
REQ-022 o_busy SHALL be 1 in every state except IDLE.
REQ-023 If i_frozen falls during a dump, an abort flag SHALL latch, the in-flight beat SHALL complete its handshake, and no further beats SHALL be issued.
REQ-024 On abort, the block SHALL pulse o_abort for 1 cycle, assert no tlast, and enter IDLE.
REQ-025 If i_frozen falls on the same cycle as the final handshake, completion SHALL win: o_done pulses and o_abort does not.
REQ-026 The sample counter SHALL be 16-bit unsigned, and all pointer compares SHALL be unsigned against DEPTH-1.

Reset
REQ-027 While i_rst=0, the state SHALL be IDLE and o_r_ram_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, o_busy, o_done, o_abort and the shadow register SHALL all be 0, asynchronously.
REQ-028 Reset mid-dump SHALL drop tvalid immediately, and no resumption SHALL occur after reset release.

Configuration
REQ-029 Macro POSTMORTEM_READER_HEADER_EN, when defined, SHALL prepend one header beat before the first sample of a dump: tdata = {last_ptr[15:0], CH_NUM[7:0], 8'hA5}, tlast=0.
REQ-030 With POSTMORTEM_READER_HEADER_EN defined, the total beat count SHALL be DEPTH*CH_NUM+1, and an abort during the header beat SHALL follow REQ-023/REQ-024.
REQ-031 Without POSTMORTEM_READER_HEADER_EN, no header logic SHALL be present and the stream SHALL start at channel 0 of the oldest sample.

Verification
REQ-032 DEPTH=8, CH_NUM=10, i_w_ram_addr=3, tready=1, i_start -> addresses read 4,5,6,7,0,1,2,3; 80 beats; tlast on beat 80 only; o_done pulse.
REQ-033 i_w_ram_addr=7 (DEPTH=8) -> first read address 0, last 7; 80 beats.
REQ-034 tready toggling 1,0,0,1 repeating -> tdata/tlast stable while stalled; word sequence identical to the tready=1 run.
REQ-035 i_frozen drops at beat 25 with tready=0 -> beat 25 completes after tready=1; no beat 26; o_abort pulse; tlast never seen; o_busy=0 afterward.
REQ-036 i_start while i_frozen=0, or while o_busy=1 -> ignored; o_r_ram_addr and stream unchanged.
REQ-037 HEADER_EN defined, i_w_ram_addr=3, DEPTH=8 -> first beat 0x00030AA5, then 80 data beats (81 total), tlast on the last.
